// File: rtl/zoom_pkg.sv
// Shared encodings for the zoom level controller: scaling algorithms, FSM states,
// and the enlarge/reduce classification of an algorithm.
package zoom_pkg;

    typedef enum logic [1:0] {
        ALG_NN = 2'd0,
        ALG_PR = 2'd1,
        ALG_DC = 2'd2,
        ALG_BA = 2'd3
    } alg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // NN/PR enlarge, DC/BA reduce: the MSB of the encoding selects the direction.
    function automatic logic is_enlarge(input alg_t alg);
        return ~alg[1];
    endfunction

endpackage

// File: rtl/zoom_dim_calc.sv
// Combinational image-dimension calculator: maps a signed zoom level to
// width/height by shifting the level-0 base dimensions.
module zoom_dim_calc
    import zoom_pkg::*;
#(
    parameter int BASE_W   = 160,
    parameter int BASE_H   = 120,
    parameter int W_BITS   = 11,
    parameter int H_BITS   = 10,
    parameter int LVL_BITS = 3
) (
    input  logic signed [LVL_BITS-1:0] level,
    output logic        [W_BITS-1:0]   width,
    output logic        [H_BITS-1:0]   height
);

    localparam logic [W_BITS-1:0] BW = W_BITS'(BASE_W);
    localparam logic [H_BITS-1:0] BH = H_BITS'(BASE_H);

    logic                neg;
    logic [LVL_BITS-1:0] mag;

    assign neg = level[LVL_BITS-1];
    assign mag = neg ? $unsigned(-level) : $unsigned(level);

    // Right shifts are exact because the base is divisible by 2**MAX_DOWN.
    assign width  = neg ? (BW >> mag) : (BW << mag);
    assign height = neg ? (BH >> mag) : (BH << mag);

endmodule

// File: rtl/zoom_level_controller.sv
// Multi-level zoom controller: algorithm select, START/op_done handshake with the
// scaling engine, signed level tracking and registered output dimensions.
// Optional watchdog on the engine handshake when ZOOM_TIMEOUT_EN is defined.
module zoom_level_controller
    import zoom_pkg::*;
#(
    parameter int BASE_W    = 160,
    parameter int BASE_H    = 120,
    parameter int MAX_UP    = 2,
    parameter int MAX_DOWN  = 2,
    parameter int W_BITS    = 11,
    parameter int H_BITS    = 10,
    parameter int LVL_BITS  = 3,
    parameter int TO_CYCLES = 1023
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       SELECT,
    input  logic                       zoom_requested,
    input  logic                       zoom_restore,
    input  logic                       op_done,
    output alg_t                       ALGORITHM,
    output logic                       START,
    output alg_t                       OP_ALG,
    output logic                       BUSY,
    output logic                       RESTORE,
    output logic                       REJECT,
    output logic signed [LVL_BITS-1:0] ZOOM_LEVEL,
    output logic        [W_BITS-1:0]   IMG_WIDTH_OUT,
    output logic        [H_BITS-1:0]   IMG_HEIGHT_OUT,
    output logic                       TIMEOUT_ERR
);

    localparam logic signed [LVL_BITS-1:0] LVL_MAX = LVL_BITS'(MAX_UP);
    localparam logic signed [LVL_BITS-1:0] LVL_MIN = LVL_BITS'(-MAX_DOWN);
    localparam logic signed [LVL_BITS-1:0] LVL_ONE = LVL_BITS'(1);

    if (BASE_W % (1 << MAX_DOWN) != 0 || BASE_H % (1 << MAX_DOWN) != 0) begin : g_bad_base
        $error("BASE_W/BASE_H must be divisible by 2**MAX_DOWN");
    end
    if (TO_CYCLES < 1) begin : g_bad_to
        $error("TO_CYCLES must be at least 1");
    end

    state_t                     state;
    logic signed [LVL_BITS-1:0] lvl_nxt;
    logic        [W_BITS-1:0]   calc_w;
    logic        [H_BITS-1:0]   calc_h;
    logic                       at_limit;

`ifdef ZOOM_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
`endif

    assign at_limit = is_enlarge(ALGORITHM) ? (ZOOM_LEVEL == LVL_MAX)
                                            : (ZOOM_LEVEL == LVL_MIN);

    // The level about to be committed; dims are derived from it so both update together.
    always_comb begin
        lvl_nxt = ZOOM_LEVEL;
        if (state == ST_IDLE && zoom_restore)
            lvl_nxt = '0;
        else if (state == ST_WAIT && op_done)
            lvl_nxt = is_enlarge(OP_ALG) ? ZOOM_LEVEL + LVL_ONE : ZOOM_LEVEL - LVL_ONE;
    end

    zoom_dim_calc #(
        .BASE_W  (BASE_W),
        .BASE_H  (BASE_H),
        .W_BITS  (W_BITS),
        .H_BITS  (H_BITS),
        .LVL_BITS(LVL_BITS)
    ) u_dim_calc (
        .level (lvl_nxt),
        .width (calc_w),
        .height(calc_h)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= ST_IDLE;
            ALGORITHM      <= ALG_NN;
            OP_ALG         <= ALG_NN;
            START          <= 1'b0;
            BUSY           <= 1'b0;
            RESTORE        <= 1'b0;
            REJECT         <= 1'b0;
            TIMEOUT_ERR    <= 1'b0;
            ZOOM_LEVEL     <= '0;
            IMG_WIDTH_OUT  <= W_BITS'(BASE_W);
            IMG_HEIGHT_OUT <= H_BITS'(BASE_H);
`ifdef ZOOM_TIMEOUT_EN
            to_cnt         <= '0;
`endif
        end else begin
            START          <= 1'b0;
            RESTORE        <= 1'b0;
            REJECT         <= 1'b0;
            TIMEOUT_ERR    <= 1'b0;
            ZOOM_LEVEL     <= lvl_nxt;
            IMG_WIDTH_OUT  <= calc_w;
            IMG_HEIGHT_OUT <= calc_h;
            case (state)
                ST_IDLE: begin
                    if (zoom_restore) begin
                        RESTORE <= 1'b1;
                    end else if (zoom_requested) begin
                        if (at_limit) begin
                            REJECT <= 1'b1;
                        end else begin
                            OP_ALG <= ALGORITHM;
                            START  <= 1'b1;
                            BUSY   <= 1'b1;
                            state  <= ST_ISSUE;
                        end
                    end else if (SELECT) begin
                        ALGORITHM <= alg_t'(ALGORITHM + 2'd1);
                    end
                end
                ST_ISSUE: begin
                    if (zoom_requested || zoom_restore)
                        REJECT <= 1'b1;
                    state <= ST_WAIT;
`ifdef ZOOM_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (zoom_requested || zoom_restore)
                        REJECT <= 1'b1;
                    if (op_done) begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
`ifdef ZOOM_TIMEOUT_EN
                    end else if (to_cnt == TO_W'(TO_CYCLES - 1)) begin
                        TIMEOUT_ERR <= 1'b1;
                        BUSY        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zoom_level_controller.sv
// Scoreboard bench for zoom_level_controller: expected OP_ALG and committed
// level/dims are queued at request time and checked when START / BUSY-fall appear.
module tb_zoom_level_controller;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              SELECT, zoom_requested, zoom_restore, op_done;
    logic [1:0]        ALGORITHM, OP_ALG;
    logic              START, BUSY, RESTORE, REJECT, TIMEOUT_ERR;
    logic signed [2:0] ZOOM_LEVEL;
    logic [10:0]       IMG_WIDTH_OUT;
    logic [9:0]        IMG_HEIGHT_OUT;

    typedef struct {
        int lvl;
        int w;
        int h;
    } res_t;

    int   sb_start[$];
    res_t sb_res[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_busy = 1'b0;

    zoom_level_controller #(.TO_CYCLES(8)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .SELECT        (SELECT),
        .zoom_requested(zoom_requested),
        .zoom_restore  (zoom_restore),
        .op_done       (op_done),
        .ALGORITHM     (ALGORITHM),
        .START         (START),
        .OP_ALG        (OP_ALG),
        .BUSY          (BUSY),
        .RESTORE       (RESTORE),
        .REJECT        (REJECT),
        .ZOOM_LEVEL    (ZOOM_LEVEL),
        .IMG_WIDTH_OUT (IMG_WIDTH_OUT),
        .IMG_HEIGHT_OUT(IMG_HEIGHT_OUT),
        .TIMEOUT_ERR   (TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_w(input int l);
        return (l >= 0) ? (160 * (1 << l)) : (160 / (1 << -l));
    endfunction

    function automatic int exp_h(input int l);
        return (l >= 0) ? (120 * (1 << l)) : (120 / (1 << -l));
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: START pops the expected algorithm, a normal BUSY fall pops the commit.
    always @(negedge CLK) begin
        if (RESET) begin
            prev_busy <= 1'b0;
        end else begin
            if (START) begin
                if (sb_start.size() == 0) chk("sb_start_underflow", 1, 0);
                else chk("op_alg", int'(OP_ALG), sb_start.pop_front());
            end
            if (prev_busy && !BUSY && !TIMEOUT_ERR) begin
                if (sb_res.size() == 0) begin
                    chk("sb_res_underflow", 1, 0);
                end else begin
                    res_t r;
                    r = sb_res.pop_front();
                    chk("commit_level", int'(ZOOM_LEVEL), r.lvl);
                    chk("commit_width", int'(IMG_WIDTH_OUT), r.w);
                    chk("commit_height", int'(IMG_HEIGHT_OUT), r.h);
                end
            end
            prev_busy <= BUSY;
        end
    end

    task automatic pulse_select();
        SELECT = 1'b1;
        tick();
        SELECT = 1'b0;
    endtask

    task automatic pulse_restore();
        zoom_restore = 1'b1;
        tick();
        zoom_restore = 1'b0;
        chk("restore_pulse", int'(RESTORE), 1);
        chk("restore_level", int'(ZOOM_LEVEL), 0);
        chk("restore_width", int'(IMG_WIDTH_OUT), 160);
        chk("restore_height", int'(IMG_HEIGHT_OUT), 120);
    endtask

    // One zoom request; ok=0 expects a REJECT, otherwise op_done comes dly cycles after START.
    task automatic do_zoom(input bit ok, input int lvl, input int dly);
        if (ok) begin
            sb_start.push_back(int'(ALGORITHM));
            sb_res.push_back('{lvl, exp_w(lvl), exp_h(lvl)});
        end
        zoom_requested = 1'b1;
        tick();
        zoom_requested = 1'b0;
        chk("start", int'(START), int'(ok));
        chk("reject", int'(REJECT), int'(!ok));
        if (ok) begin
            repeat (dly) tick();
            chk("busy_wait", int'(BUSY), 1);
            op_done = 1'b1;
            tick();
            op_done = 1'b0;
            chk("busy_done", int'(BUSY), 0);
        end
    endtask

    initial begin
        RESET = 1'b1;
        SELECT = 1'b0;
        zoom_requested = 1'b0;
        zoom_restore = 1'b0;
        op_done = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;

        chk("rst_alg", int'(ALGORITHM), 0);
        chk("rst_level", int'(ZOOM_LEVEL), 0);
        chk("rst_width", int'(IMG_WIDTH_OUT), 160);
        chk("rst_height", int'(IMG_HEIGHT_OUT), 120);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_start", int'(START), 0);

        // Algorithm cycling
        for (int i = 1; i <= 4; i++) begin
            pulse_select();
            chk("select_alg", int'(ALGORITHM), i % 4);
        end

        // NN enlarge to the upper limit
        do_zoom(1'b1, 1, 5);
        do_zoom(1'b1, 2, 2);
        do_zoom(1'b0, 2, 0);
        chk("limit_width", int'(IMG_WIDTH_OUT), 640);
        chk("limit_height", int'(IMG_HEIGHT_OUT), 480);

        // SELECT alongside a request is dropped
        SELECT = 1'b1;
        zoom_requested = 1'b1;
        tick();
        SELECT = 1'b0;
        zoom_requested = 1'b0;
        chk("select_dropped", int'(ALGORITHM), 0);
        chk("select_dropped_rej", int'(REJECT), 1);

        pulse_restore();

        // BA reduce to the lower limit
        repeat (3) pulse_select();
        chk("alg_ba", int'(ALGORITHM), 3);
        do_zoom(1'b1, -1, 3);
        do_zoom(1'b1, -2, 4);
        do_zoom(1'b0, -2, 0);
        chk("low_width", int'(IMG_WIDTH_OUT), 40);
        pulse_restore();
        pulse_restore();

        // Requests while busy
        sb_start.push_back(3);
        sb_res.push_back('{-1, 80, 60});
        zoom_requested = 1'b1;
        tick();
        zoom_requested = 1'b0;
        chk("busy_start", int'(START), 1);
        zoom_requested = 1'b1;
        tick();
        zoom_requested = 1'b0;
        chk("busy_req_rej", int'(REJECT), 1);
        chk("busy_no_start", int'(START), 0);
        zoom_restore = 1'b1;
        tick();
        zoom_restore = 1'b0;
        chk("busy_rst_rej", int'(REJECT), 1);
        chk("busy_no_restore", int'(RESTORE), 0);
        chk("busy_level", int'(ZOOM_LEVEL), 0);
        SELECT = 1'b1;
        tick();
        SELECT = 1'b0;
        chk("busy_select", int'(ALGORITHM), 3);
        chk("busy_select_norej", int'(REJECT), 0);
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        chk("busy_commit_busy", int'(BUSY), 0);

        // Reset in WAIT aborts without commit
        sb_start.push_back(3);
        zoom_requested = 1'b1;
        tick();
        zoom_requested = 1'b0;
        repeat (2) tick();
        chk("pre_reset_busy", int'(BUSY), 1);
        RESET = 1'b1;
        #1;
        chk("abort_level", int'(ZOOM_LEVEL), 0);
        chk("abort_width", int'(IMG_WIDTH_OUT), 160);
        chk("abort_height", int'(IMG_HEIGHT_OUT), 120);
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_alg", int'(ALGORITHM), 0);
        tick();
        RESET = 1'b0;
        tick();

`ifdef ZOOM_TIMEOUT_EN
        begin
            int n;
            n = 0;
            sb_start.push_back(0);
            zoom_requested = 1'b1;
            tick();
            zoom_requested = 1'b0;
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (TIMEOUT_ERR) begin
                    n = i;
                    break;
                end
            end
            chk("timeout_cycle", n, 9);
            chk("timeout_busy", int'(BUSY), 0);
            chk("timeout_level", int'(ZOOM_LEVEL), 0);
            chk("timeout_width", int'(IMG_WIDTH_OUT), 160);
        end
`else
        chk("no_timeout", int'(TIMEOUT_ERR), 0);
`endif

        tick();
        chk("sb_start_left", sb_start.size(), 0);
        chk("sb_res_left", sb_res.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
